// File: rtl/sky130_fd_io__lvc_pwrgood_seq.sv
// rtl/sky130_fd_io__lvc_pwrgood_seq.sv - power-good qualifier and staggered enable sequencer
// Synchronizes/debounces the core-supply detect flag, then raises enables in order and PWR_GOOD last.
module sky130_fd_io__lvc_pwrgood_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 64,
    parameter int STEP_CYCLES = 16,
    parameter int NUM_EN      = 3,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              P_CORE_DET,
    input  logic              HOLD,
    output logic [NUM_EN-1:0] EN_OUT,
    output logic              PWR_GOOD,
    output logic [1:0]        STATE,
    output logic [3:0]        GLITCH_CNT
);

    localparam int IDX_W = (NUM_EN > 1) ? $clog2(NUM_EN) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_EN - 1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_SEQ      = 2'd2,
        ST_GOOD     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   det_s;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_EN-1:0]  en_q, en_d;
    logic               pg_q, pg_d;
    logic [3:0]         glitch_q, glitch_d;

    // P_CORE_DET is asynchronous; only the last stage is ever consumed.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], P_CORE_DET};
        end
    end

    assign det_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            idx_q    <= '0;
            en_q     <= '0;
            pg_q     <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            pg_q     <= pg_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        en_d     = en_q;
        pg_d     = pg_q;
        glitch_d = glitch_q;

        if (state_q != ST_OFF && (HOLD || !det_s)) begin
            // Collapse everything on one edge; HOLD masks the glitch count.
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
            en_d    = '0;
            pg_d    = 1'b0;
            if (!HOLD && glitch_q != 4'hF) begin
                glitch_d = glitch_q + 4'd1;
            end
        end else begin
            case (state_q)
                ST_OFF: begin
                    cnt_d = '0;
                    idx_d = '0;
                    en_d  = '0;
                    pg_d  = 1'b0;
                    if (det_s && !HOLD) begin
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_SEQ;
                        cnt_d   = '0;
                        idx_d   = '0;
                        en_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SEQ: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_GOOD;
                            pg_d    = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            for (int k = 0; k < NUM_EN; k++) begin
                                if (IDX_W'(k) == idx_d) begin
                                    en_d[k] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_GOOD;
                end
            endcase
        end
    end

    assign EN_OUT     = en_q;
    assign PWR_GOOD   = pg_q;
    assign STATE      = state_q;
    assign GLITCH_CNT = glitch_q;

endmodule

// File: tb/tb_sky130_fd_io__lvc_pwrgood_seq.sv
// tb/tb_sky130_fd_io__lvc_pwrgood_seq.sv - directed self-checking bench for the power-good sequencer
module tb_sky130_fd_io__lvc_pwrgood_seq;

    logic       clk;
    logic       reset_b;
    logic       p_det;
    logic       hold;
    logic [2:0] en_out;
    logic       pwr_good;
    logic [1:0] state;
    logic [3:0] glitch_cnt;

    logic       p_det_b;
    logic       hold_b;
    logic [0:0] en_out_b;
    logic       pwr_good_b;
    logic [1:0] state_b;
    logic [3:0] glitch_cnt_b;

    int checks;
    int failures;

    sky130_fd_io__lvc_pwrgood_seq dut (
        .CLK(clk), .RESET_B(reset_b), .P_CORE_DET(p_det), .HOLD(hold),
        .EN_OUT(en_out), .PWR_GOOD(pwr_good), .STATE(state), .GLITCH_CNT(glitch_cnt)
    );

    sky130_fd_io__lvc_pwrgood_seq #(
        .SYNC_STAGES(2), .DEB_CYCLES(1), .STEP_CYCLES(1), .NUM_EN(1), .CNT_W(8)
    ) dut_corner (
        .CLK(clk), .RESET_B(reset_b), .P_CORE_DET(p_det_b), .HOLD(hold_b),
        .EN_OUT(en_out_b), .PWR_GOOD(pwr_good_b), .STATE(state_b), .GLITCH_CNT(glitch_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0; p_det = 1'b0; hold = 1'b0; p_det_b = 1'b0; hold_b = 1'b0;
        step(2);
        checks++; if (en_out !== 3'b000) begin failures++; $display("FAIL rst_en got=%b exp=000", en_out); end
        checks++; if (pwr_good !== 1'b0) begin failures++; $display("FAIL rst_pg got=%b exp=0", pwr_good); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (glitch_cnt !== 4'd0) begin failures++; $display("FAIL rst_glitch got=%0d exp=0", glitch_cnt); end
        reset_b = 1'b1;
        step(3);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", state); end
    endtask

    task automatic test_power_up();
        p_det = 1'b1;
        step(3);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL pu_deb_state got=%0d exp=1", state); end
        step(63);
        checks++; if (en_out !== 3'b000) begin failures++; $display("FAIL pu_en_e66 got=%b exp=000", en_out); end
        step(1);
        checks++; if (en_out !== 3'b001) begin failures++; $display("FAIL pu_en_e67 got=%b exp=001", en_out); end
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL pu_seq_state got=%0d exp=2", state); end
        step(15);
        checks++; if (en_out !== 3'b001) begin failures++; $display("FAIL pu_en_e82 got=%b exp=001", en_out); end
        step(1);
        checks++; if (en_out !== 3'b011) begin failures++; $display("FAIL pu_en_e83 got=%b exp=011", en_out); end
        step(16);
        checks++; if (en_out !== 3'b111) begin failures++; $display("FAIL pu_en_e99 got=%b exp=111", en_out); end
        step(15);
        checks++; if (pwr_good !== 1'b0) begin failures++; $display("FAIL pu_pg_e114 got=%b exp=0", pwr_good); end
        step(1);
        checks++; if (pwr_good !== 1'b1) begin failures++; $display("FAIL pu_pg_e115 got=%b exp=1", pwr_good); end
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL pu_good_state got=%0d exp=3", state); end
        checks++; if (glitch_cnt !== 4'd0) begin failures++; $display("FAIL pu_glitch got=%0d exp=0", glitch_cnt); end
        step(10);
        checks++; if (en_out !== 3'b111 || pwr_good !== 1'b1) begin failures++; $display("FAIL pu_hold_good got=%b/%b exp=111/1", en_out, pwr_good); end
    endtask

    task automatic test_brownout();
        p_det = 1'b0;
        step(2);
        checks++; if (en_out !== 3'b111) begin failures++; $display("FAIL bo_en_e2 got=%b exp=111", en_out); end
        step(1);
        checks++; if (en_out !== 3'b000 || pwr_good !== 1'b0) begin failures++; $display("FAIL bo_off_e3 got=%b/%b exp=000/0", en_out, pwr_good); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL bo_state got=%0d exp=0", state); end
        checks++; if (glitch_cnt !== 4'd1) begin failures++; $display("FAIL bo_glitch got=%0d exp=1", glitch_cnt); end
        step(5);
        checks++; if (glitch_cnt !== 4'd1) begin failures++; $display("FAIL bo_off_nocount got=%0d exp=1", glitch_cnt); end
    endtask

    task automatic test_debounce_glitch();
        p_det = 1'b1;
        step(30);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL dg_deb_state got=%0d exp=1", state); end
        p_det = 1'b0;
        step(5);
        checks++; if (state !== 2'd0 || en_out !== 3'b000) begin failures++; $display("FAIL dg_off got=%0d/%b exp=0/000", state, en_out); end
        checks++; if (glitch_cnt !== 4'd2) begin failures++; $display("FAIL dg_glitch got=%0d exp=2", glitch_cnt); end
        p_det = 1'b1;
        step(66);
        checks++; if (en_out !== 3'b000) begin failures++; $display("FAIL dg_en_e66 got=%b exp=000", en_out); end
        step(1);
        checks++; if (en_out !== 3'b001) begin failures++; $display("FAIL dg_en_e67 got=%b exp=001", en_out); end
    endtask

    task automatic test_hold();
        step(16);
        checks++; if (en_out !== 3'b011) begin failures++; $display("FAIL hd_pre got=%b exp=011", en_out); end
        hold = 1'b1;
        step(1);
        checks++; if (en_out !== 3'b000 || state !== 2'd0) begin failures++; $display("FAIL hd_off got=%b/%0d exp=000/0", en_out, state); end
        checks++; if (glitch_cnt !== 4'd2) begin failures++; $display("FAIL hd_glitch got=%0d exp=2", glitch_cnt); end
        step(5);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL hd_stay_off got=%0d exp=0", state); end
        hold = 1'b0;
        step(1);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL hd_release got=%0d exp=1", state); end
        step(63);
        checks++; if (en_out !== 3'b000) begin failures++; $display("FAIL hd_en_pre got=%b exp=000", en_out); end
        step(1);
        checks++; if (en_out !== 3'b001) begin failures++; $display("FAIL hd_en0 got=%b exp=001", en_out); end
        step(16);
        checks++; if (en_out !== 3'b011) begin failures++; $display("FAIL hd2_pre got=%b exp=011", en_out); end
        p_det = 1'b0;
        step(2);
        hold = 1'b1;
        step(1);
        checks++; if (en_out !== 3'b000 || state !== 2'd0) begin failures++; $display("FAIL hd2_off got=%b/%0d exp=000/0", en_out, state); end
        checks++; if (glitch_cnt !== 4'd2) begin failures++; $display("FAIL hd2_glitch got=%0d exp=2", glitch_cnt); end
        hold = 1'b0;
        step(3);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL hd2_idle got=%0d exp=0", state); end
    endtask

    task automatic test_async_reset();
        p_det = 1'b1;
        step(83);
        checks++; if (en_out !== 3'b011) begin failures++; $display("FAIL ar_pre got=%b exp=011", en_out); end
        #1;
        reset_b = 1'b0;
        #1;
        checks++; if (en_out !== 3'b000 || pwr_good !== 1'b0) begin failures++; $display("FAIL ar_immediate got=%b/%b exp=000/0", en_out, pwr_good); end
        checks++; if (state !== 2'd0 || glitch_cnt !== 4'd0) begin failures++; $display("FAIL ar_state got=%0d/%0d exp=0/0", state, glitch_cnt); end
        reset_b = 1'b1;
        step(66);
        checks++; if (en_out !== 3'b000) begin failures++; $display("FAIL ar_replay_e66 got=%b exp=000", en_out); end
        step(1);
        checks++; if (en_out !== 3'b001) begin failures++; $display("FAIL ar_replay_e67 got=%b exp=001", en_out); end
    endtask

    task automatic test_saturation();
        p_det = 1'b0;
        step(3);
        checks++; if (glitch_cnt !== 4'd1) begin failures++; $display("FAIL sat_first got=%0d exp=1", glitch_cnt); end
        for (int i = 2; i <= 17; i++) begin
            p_det = 1'b1;
            step(4);
            p_det = 1'b0;
            step(3);
            if (i == 14) begin
                checks++; if (glitch_cnt !== 4'd14) begin failures++; $display("FAIL sat_14 got=%0d exp=14", glitch_cnt); end
            end
        end
        checks++; if (glitch_cnt !== 4'd15) begin failures++; $display("FAIL sat_17 got=%0d exp=15", glitch_cnt); end
    endtask

    task automatic test_corner_params();
        p_det_b = 1'b1;
        step(3);
        checks++; if (en_out_b !== 1'b0 || state_b !== 2'd1) begin failures++; $display("FAIL cp_e3 got=%b/%0d exp=0/1", en_out_b, state_b); end
        step(1);
        checks++; if (en_out_b !== 1'b1 || pwr_good_b !== 1'b0) begin failures++; $display("FAIL cp_e4 got=%b/%b exp=1/0", en_out_b, pwr_good_b); end
        step(1);
        checks++; if (pwr_good_b !== 1'b1 || state_b !== 2'd3) begin failures++; $display("FAIL cp_e5 got=%b/%0d exp=1/3", pwr_good_b, state_b); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_power_up();
        test_brownout();
        test_debounce_glitch();
        test_hold();
        test_async_reset();
        test_saturation();
        test_corner_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
